// File: rtl/cache_pkg.sv
// Shared cache definitions: default data RAM geometry and the line-fill state enum.
// Used by cache_data_port and by the cache controller FSM.
// Contents: ADDR_W/LINE_WORDS defaults, derived offset/line widths, state_e.
package cache_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int LINE_WORDS_DEF = 8;
  localparam int OFF_W_DEF      = $clog2(LINE_WORDS_DEF);
  localparam int LINE_W_DEF     = ADDR_W_DEF - OFF_W_DEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/cache_data_port.sv
// Purpose: sole owner of the 1024x32 data RAM port; writes streamed line-fill
//   words, arbitrates hit-path reads around them and returns read data.
// Latency: fill word written the cycle it is accepted; read data one cycle after grant.
// Backpressure: fill has priority; reads wait on fill writes and on any read into
//   the line being filled. fill_ready_o is high for the whole FILL state.
// Ports: fill_* (line-fill stream in), rd_* (read request/return), ram_* (RAM port),
//   busy_o (fill in progress).
module cache_data_port
  import cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   fill_start_i,
  input  logic [ADDR_W-$clog2(LINE_WORDS)-1:0]   fill_line_i,
  input  logic                                   fill_valid_i,
  input  logic [31:0]                            fill_data_i,
  output logic                                   fill_ready_o,
  output logic                                   fill_done_o,
  input  logic                                   rd_req_i,
  input  logic [ADDR_W-1:0]                      rd_addr_i,
  output logic                                   rd_gnt_o,
  output logic                                   rd_valid_o,
  output logic [31:0]                            rd_data_o,
  output logic                                   ram_en_o,
  output logic [ADDR_W-1:0]                      ram_addr_o,
  output logic [31:0]                            ram_di_o,
  output logic [3:0]                             ram_we_o,
  input  logic [31:0]                            ram_do_i,
  output logic                                   busy_o
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = ADDR_W - OFF_W;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic                fill_done_q, fill_done_d;
  logic                rd_valid_q, rd_valid_d;
  logic [31:0]         rd_hold_q, rd_hold_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         ram_di_q, ram_di_d;

  logic                fill_write;
  logic                hazard;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic, including the line latch and word counter
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    fill_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fill_start_i) begin
          state_d = ST_FILL;
          line_d  = fill_line_i;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        if (fill_write) begin
          // Counter is exactly OFF_W bits, so the last word wraps it back to 0.
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            state_d     = ST_IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: fill handshake, read arbitration and RAM port mux
  always_comb begin
    fill_ready_o = (state_q == ST_FILL);
    busy_o       = (state_q == ST_FILL);
    fill_write   = fill_valid_i & fill_ready_o;
    // A read into the line being filled could return stale data, so it waits
    // for the whole fill to finish.
    hazard       = (state_q == ST_FILL) && (rd_addr_i[ADDR_W-1:OFF_W] == line_q);
    rd_gnt_o     = rd_req_i & ~fill_write & ~hazard;

    ram_en_o   = fill_write | rd_gnt_o;
    ram_we_o   = fill_write ? 4'hF : 4'h0;
    // Address and write data keep the last source's value when the port is idle.
    ram_addr_o = ram_addr_q;
    ram_di_o   = ram_di_q;
    if (fill_write) begin
      ram_addr_o = {line_q, cnt_q};
      ram_di_o   = fill_data_i;
    end else if (rd_gnt_o) begin
      ram_addr_o = rd_addr_i;
    end

    fill_done_o = fill_done_q;
    rd_valid_o  = rd_valid_q;
    // Do0 also reflects fill writes, so outside the return cycle the last read
    // word is served from the holding register.
    rd_data_o   = rd_valid_q ? ram_do_i : rd_hold_q;
  end

  always_comb begin
    rd_valid_d = rd_gnt_o;
    rd_hold_d  = rd_valid_q ? ram_do_i : rd_hold_q;
    ram_addr_d = ram_addr_o;
    ram_di_d   = ram_di_o;
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q      <= '0;
      cnt_q       <= '0;
      fill_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_hold_q   <= '0;
      ram_addr_q  <= '0;
      ram_di_q    <= '0;
    end else begin
      line_q      <= line_d;
      cnt_q       <= cnt_d;
      fill_done_q <= fill_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_hold_q   <= rd_hold_d;
      ram_addr_q  <= ram_addr_d;
      ram_di_q    <= ram_di_d;
    end
  end

endmodule
